// File: rtl/rr_bank_arbiter.sv
// Round-robin arbiter between NCONSUMERS requesters and a banked PLM, one kernel per bank port.
// Define RR_ARB_STALL_COUNT_EN to add per-consumer saturating stall counters (stall_count).
module rr_bank_arbiter #(
    parameter int ADDR_WIDTH       = 4,
    parameter int VALUE_WIDTH      = 8,
    parameter int NCONSUMERS       = 3,
    parameter int NBANKS           = 2,
    parameter int NPORTS           = 1,
    parameter int PLM_READ_LATENCY = 1,
    localparam int NUM_BANK_BITS   = $clog2(NBANKS),
    localparam int NKERNELS        = NBANKS * NPORTS,
    localparam int LA_W            = ADDR_WIDTH - NUM_BANK_BITS,
    localparam int REQ_W           = ADDR_WIDTH + VALUE_WIDTH + 2,
    localparam int PI_W            = LA_W + VALUE_WIDTH + 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NCONSUMERS-1:0][REQ_W-1:0]       requests,
    output logic [NCONSUMERS-1:0]                  grants,
    output logic [NKERNELS-1:0][PI_W-1:0]          plm_inputs,
    input  logic [NKERNELS-1:0][VALUE_WIDTH-1:0]   plm_outputs,
    output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] responses,
    output logic [NCONSUMERS-1:0]                  resp_valid
`ifdef RR_ARB_STALL_COUNT_EN
    ,
    output logic [NCONSUMERS-1:0][15:0]            stall_count
`endif
);

    localparam int CW  = $clog2(NCONSUMERS);
    localparam int KW  = (NKERNELS > 1) ? $clog2(NKERNELS) : 1;
    localparam int BW  = (NUM_BANK_BITS > 0) ? NUM_BANK_BITS : 1;
    localparam int LAT = PLM_READ_LATENCY;

    logic [NCONSUMERS-1:0][BW-1:0]               req_bank;
    logic [NKERNELS-1:0][CW-1:0]                 pivot_q, pivot_d, pivot_rst;
    logic [NCONSUMERS-1:0]                       push_vld;
    logic [NCONSUMERS-1:0][KW-1:0]               push_kid;
    logic [LAT-1:0][NCONSUMERS-1:0]              tag_vld_q, tag_vld_d;
    logic [LAT-1:0][NCONSUMERS-1:0][KW-1:0]      tag_kid_q, tag_kid_d;
    logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0]      responses_q, responses_d;
    logic [NCONSUMERS-1:0]                       resp_valid_q, resp_valid_d;

    for (genvar c = 0; c < NCONSUMERS; c++) begin : g_bank
        if (NUM_BANK_BITS == 0) begin : g_single
            assign req_bank[c] = '0;
        end else begin : g_multi
            assign req_bank[c] = requests[c][REQ_W-1 -: NUM_BANK_BITS];
        end
    end

    // Ports of a bank start spread apart so they do not chase the same consumer.
    for (genvar k = 0; k < NKERNELS; k++) begin : g_prst
        assign pivot_rst[k] = CW'((k / NPORTS + (k % NPORTS) * (NCONSUMERS / NPORTS)) % NCONSUMERS);
    end

    // Kernels resolve in index order, so port 0 of a bank always claims before port 1.
    always_comb begin
        logic [NCONSUMERS-1:0] taken;
        logic [CW:0]           idx;
        logic [CW-1:0]         w;
        logic                  won;
        taken      = '0;
        grants     = '0;
        plm_inputs = '0;
        push_vld   = '0;
        push_kid   = '0;
        pivot_d    = pivot_q;
        idx        = '0;
        w          = '0;
        won        = 1'b0;
        for (int k = 0; k < NKERNELS; k++) begin
            won = 1'b0;
            for (int i = 0; i < NCONSUMERS; i++) begin
                idx = {1'b0, pivot_q[k]} + (CW+1)'(i);
                if (idx >= (CW+1)'(NCONSUMERS))
                    idx = idx - (CW+1)'(NCONSUMERS);
                w = idx[CW-1:0];
                if (reset && !won && !taken[w] && requests[w][0] && req_bank[w] == BW'(k / NPORTS)) begin
                    won           = 1'b1;
                    taken[w]      = 1'b1;
                    grants[w]     = 1'b1;
                    plm_inputs[k] = requests[w][PI_W:1];
                    pivot_d[k]    = (w == CW'(NCONSUMERS - 1)) ? '0 : w + CW'(1);
                    if (!requests[w][1]) begin
                        push_vld[w] = 1'b1;
                        push_kid[w] = KW'(k);
                    end
                end
            end
        end
    end

    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_kid_d    = tag_kid_q;
        tag_vld_d[0] = push_vld;
        tag_kid_d[0] = push_kid;
        for (int j = 1; j < LAT; j++) begin
            tag_vld_d[j] = tag_vld_q[j-1];
            tag_kid_d[j] = tag_kid_q[j-1];
        end
        responses_d  = responses_q;
        resp_valid_d = '0;
        for (int c = 0; c < NCONSUMERS; c++) begin
            if (tag_vld_q[LAT-1][c]) begin
                resp_valid_d[c] = 1'b1;
                responses_d[c]  = plm_outputs[tag_kid_q[LAT-1][c]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pivot_q      <= pivot_rst;
            tag_vld_q    <= '0;
            tag_kid_q    <= '0;
            responses_q  <= '0;
            resp_valid_q <= '0;
        end else begin
            pivot_q      <= pivot_d;
            tag_vld_q    <= tag_vld_d;
            tag_kid_q    <= tag_kid_d;
            responses_q  <= responses_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign responses  = responses_q;
    assign resp_valid = resp_valid_q;

`ifdef RR_ARB_STALL_COUNT_EN
    logic [NCONSUMERS-1:0][15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        for (int c = 0; c < NCONSUMERS; c++) begin
            if (requests[c][0] && !grants[c] && stall_q[c] != 16'hFFFF)
                stall_d[c] = stall_q[c] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`else
`endif

endmodule

// File: tb/tb_rr_bank_arbiter.sv
// Randomized scoreboard bench for rr_bank_arbiter (3 consumers, 2 banks, dual-port, read latency 2).
module tb_rr_bank_arbiter;
    localparam int AW = 4, VW = 8, NC = 3, NB = 2, NP = 2, LAT = 2;
    localparam int NK = NB * NP, LAW = AW - 1, REQW = AW + VW + 2, PIW = LAW + VW + 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NC-1:0][REQW-1:0] requests;
    logic [NC-1:0]           grants;
    logic [NK-1:0][PIW-1:0]  plm_inputs;
    logic [NK-1:0][VW-1:0]   plm_outputs;
    logic [NC-1:0][VW-1:0]   responses;
    logic [NC-1:0]           resp_valid;
`ifdef RR_ARB_STALL_COUNT_EN
    logic [NC-1:0][15:0]     stall_count;
    int                      stall_m [NC];
`endif

    rr_bank_arbiter #(
        .ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC),
        .NBANKS(NB), .NPORTS(NP), .PLM_READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .requests(requests), .grants(grants),
        .plm_inputs(plm_inputs), .plm_outputs(plm_outputs),
        .responses(responses), .resp_valid(resp_valid)
`ifdef RR_ARB_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         cons;
        logic [7:0] data;
    } exp_t;

    exp_t exq[$];
    int   n_vec = 0, n_err = 0;

    // consumer-side model state: a request is held until the model grants it
    bit   pend [NC];
    int   addr [NC];
    int   val  [NC];
    bit   wr   [NC];
    int   piv  [NK];
    bit   rst_edge;
    logic [NK-1:0][PIW-1:0] cap_ring [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // PLM model: read data is a fixed function of kernel, local address and capture cycle
    function automatic logic [7:0] pdata(input int k, input int la, input int t);
        return 8'(k * 37 + la * 11 + t * 5 + 90);
    endfunction

    function automatic int piv_reset(input int k);
        return (k / NP + (k % NP) * (NC / NP)) % NC;
    endfunction

    // winner = eligible, unclaimed consumer at the smallest rotational distance from the pivot
    function automatic int pick(input int b, input int pv, input logic [NC-1:0] tk);
        int best  = -1;
        int bestd = NC;
        for (int c = 0; c < NC; c++) begin
            if (pend[c] && (addr[c] >> LAW) == b && !tk[c] && ((c - pv + NC) % NC) < bestd) begin
                best  = c;
                bestd = (c - pv + NC) % NC;
            end
        end
        return best;
    endfunction

    task automatic set_req(input int c, input int a, input int v, input bit w);
        pend[c] = 1'b1;
        addr[c] = a;
        val[c]  = v;
        wr[c]   = w;
    endtask

    task automatic step(input bit rst_n_in, input bit rnd);
        logic [NC-1:0]          exp_g;
        logic [NK-1:0][PIW-1:0] exp_pi;
        logic [NC-1:0]          tk;
        logic [PIW-1:0]         ci;
        exp_t                   e;
        int                     w;
        @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++) begin
            ci = cap_ring[(cyc + 8 - LAT) % 8][k];
            plm_outputs[k] = pdata(k, int'(ci[PIW-1:VW+1]), cyc - LAT);
        end
        reset = rst_n_in;
        if (!rst_n_in)
            while (exq.size() > 0 && exq[exq.size()-1].due > cyc) void'(exq.pop_back());
        if (rnd)
            for (int c = 0; c < NC; c++)
                if (!pend[c] && $urandom_range(0, 2) != 0)
                    set_req(c, $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 1) == 1);
        for (int c = 0; c < NC; c++)
            requests[c] = pend[c] ? {AW'(addr[c]), VW'(val[c]), wr[c], 1'b1}
                                  : (REQW'($urandom) & ~REQW'(1));

        @(negedge clk);
        cap_ring[cyc % 8] = plm_inputs;
        exp_g  = '0;
        exp_pi = '0;
        tk     = '0;
        if (reset) begin
            for (int k = 0; k < NK; k++) begin
                w = pick(k / NP, piv[k], tk);
                if (w >= 0) begin
                    tk[w]     = 1'b1;
                    exp_g[w]  = 1'b1;
                    exp_pi[k] = {LAW'(addr[w] % 8), VW'(val[w]), wr[w]};
                    piv[k]    = (w + 1) % NC;
                    if (!wr[w]) begin
                        e.due  = cyc + LAT + 1;
                        e.cons = w;
                        e.data = pdata(k, addr[w] % 8, cyc);
                        exq.push_back(e);
                    end
                end
            end
        end
        check("grants", 64'(grants), 64'(exp_g));
        for (int k = 0; k < NK; k++)
            check($sformatf("plm_inputs[%0d]", k), 64'(plm_inputs[k]), 64'(exp_pi[k]));
        if (!rst_edge)
            for (int c = 0; c < NC; c++)
                check($sformatf("responses_after_reset[%0d]", c), 64'(responses[c]), 64'(0));
`ifdef RR_ARB_STALL_COUNT_EN
        for (int c = 0; c < NC; c++) begin
            check($sformatf("stall_count[%0d]", c), 64'(stall_count[c]), 64'(stall_m[c]));
            if (!reset)                                         stall_m[c] = 0;
            else if (pend[c] && !exp_g[c] && stall_m[c] < 65535) stall_m[c] = stall_m[c] + 1;
        end
`endif
        if (!reset)
            for (int k = 0; k < NK; k++) piv[k] = piv_reset(k);
        for (int c = 0; c < NC; c++)
            if (exp_g[c]) pend[c] = 1'b0;
        rst_edge = reset;
    endtask

    // monitor: pops every response due this cycle and compares against the DUT outputs
    initial begin
        exp_t                 e;
        logic [NC-1:0]        ev;
        logic [NC-1:0][VW-1:0] ed;
        @(posedge clk);
        @(posedge clk);
        forever begin
            @(negedge clk);
            ev = '0;
            ed = '0;
            while (exq.size() > 0 && exq[0].due <= cyc) begin
                e = exq.pop_front();
                ev[e.cons] = 1'b1;
                ed[e.cons] = e.data;
            end
            check("resp_valid", 64'(resp_valid), 64'(ev));
            for (int c = 0; c < NC; c++)
                if (ev[c]) check($sformatf("responses[%0d]", c), 64'(responses[c]), 64'(ed[c]));
        end
    end

    initial begin
        reset       = 1'b0;
        requests    = '0;
        plm_outputs = '0;
        rst_edge    = 1'b0;
        for (int i = 0; i < 8; i++) cap_ring[i] = '0;
        for (int c = 0; c < NC; c++) begin
            pend[c] = 1'b0; addr[c] = 0; val[c] = 0; wr[c] = 1'b0;
`ifdef RR_ARB_STALL_COUNT_EN
            stall_m[c] = 0;
`endif
        end
        for (int k = 0; k < NK; k++) piv[k] = piv_reset(k);

        // a request held during reset must not be granted
        set_req(0, 4'h1, 8'h11, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        // kernel 0 pivot now points at idle consumer 1; consumer 2 must win the same cycle
        set_req(2, 4'h3, 8'h22, 1'b0);
        step(1'b1, 1'b0);
        repeat (6) begin
            for (int c = 0; c < NC; c++)
                if (!pend[c]) set_req(c, $urandom_range(0, 7), c + 1, 1'b1);
            step(1'b1, 1'b0);
        end
        repeat (3) step(1'b1, 1'b0);
        // read routing through bank 1
        set_req(1, 4'h9, 8'h3C, 1'b0);
        repeat (5) step(1'b1, 1'b0);
        // two consumers on bank 0 served by both ports at once
        set_req(0, 4'h2, 8'h44, 1'b1);
        set_req(1, 4'h5, 8'h55, 1'b0);
        repeat (5) step(1'b1, 1'b0);
        // reset right after a read grant discards its response
        set_req(2, 4'hC, 8'h66, 1'b0);
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0);
        // three consumers contend for bank 1 so someone is held off for several cycles
        set_req(0, 4'h8, 8'h01, 1'b1);
        set_req(1, 4'hA, 8'h02, 1'b1);
        set_req(2, 4'hF, 8'h03, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        repeat (800) step($urandom_range(0, 59) != 0, 1'b1);
        repeat (8) step(1'b1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
